decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREGS, default 32, register count; power of two; REG_AW = clog2(NREGS).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 if_valid  in  1  instruction bundle present.
REQ-006 if_ready  out  1  stage accepts bundle this cycle.
REQ-007 instruction_i  in  32  raw RV32I instruction.
REQ-008 imm_i / pc_plus_i  in  XLEN each  immediate; PC+4.
REQ-009 pred_taken_i  in  1  branch-prediction bit.
REQ-010 flush  in  1  kill held and incoming instruction.
REQ-011 wb_we  in  1 / wb_rd  in  REG_AW / wb_data  in  XLEN  write-back port.
REQ-012 ex_ready  in  1  execute stage accepts held entry.
REQ-013 ex_valid  out  1  ID/EX entry valid.
REQ-014 a_o, b_o, store_data_o, pc_plus_o  out  XLEN  registered operands.
REQ-015 ctrl_o  out  26  registered {rd[4:0], rs2[4:0], rs1[4:0], fs[3:0], we, mr, md, mb, mem_type[2:0]}.
REQ-016 branch_sel_o  out  3 / pred_taken_o  out  1  registered.
REQ-017 stall_cnt_o  out  32  load-use stall count (present only with DECODE_HAZARD_EN).

Function
REQ-018 Register file NREGS x XLEN; register 0 reads 0, writes to it ignored; written on clk when wb_we=1.
REQ-019 Bypass: wb_we=1, wb_rd!=0, wb_rd equal to rs1/rs2 -> that read returns wb_data same cycle.
REQ-020 Fields: rd=instr[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], f7b=[30].
REQ-021 LOAD: we=1 mr=1 mb=1 fs=0000 mem_type=funct3; STORE: md=1 mb=1 fs=0000 mem_type=funct3.
REQ-022 OP: we=1 mb=0 fs={f7b,funct3}; OP-IMM: we=1 mb=1 fs={(funct3==101)&f7b,funct3}.
REQ-023 LUI/AUIPC: we=1 mb=1 fs=0000; JAL: branch_sel=001 we=1; JALR: branch_sel=010 we=1 mb=1.
REQ-024 BRANCH: branch_sel=100, mem_type=funct3, we=0; all other cases branch_sel=000.
REQ-025 instr[1:0]!=11 or unknown opcode: entire ctrl, branch_sel zero (bubble); operands still loaded.
REQ-026 b_o = imm_i when mb=1 else rs2 data; store_data_o = rs2 data always; a_o = rs1 data.
REQ-027 Handshake: if_ready = (!ex_valid | ex_ready) & !hazard; bundle accepted when if_valid & if_ready.
REQ-028 Accepted bundle loads ID/EX next edge, ex_valid=1, latency one cycle.
REQ-029 !ex_valid|ex_ready with no accept: ex_valid->0; ex_valid & !ex_ready: all outputs hold.
REQ-030 flush=1: if_ready=1, incoming discarded, ex_valid->0 next edge; flush overrides hazard and hold.
REQ-031 Hazard (macro on): ex_valid & ctrl_o.mr & ctrl_o.rd!=0 & rd matches incoming rs1 or rs2, if_valid=1.
REQ-032 Hazard with ex_ready=1: ex_valid->0 (bubble), bundle held upstream; stall exactly one cycle.
REQ-033 stall_cnt_o increments once per bubble inserted, saturates at all-ones.

Reset
REQ-034 reset=0 at edge: ex_valid, all outputs, all registers, stall_cnt_o -> 0; overrides flush, wb write.
REQ-035 reset low mid-stall: stall aborted, bundle re-presented after reset accepted normally.

Configuration
REQ-036 DECODE_HAZARD_EN defined: load-use interlock, stall_cnt_o present.
REQ-037 Undefined: hazard=0 constant, stall_cnt_o omitted, hazard resolution owned by execute.

Structure
REQ-038 Package decode_pkg: RV32I opcode constants, fs codes, branch_sel codes, ctrl field struct/offsets.
REQ-039 Sub-module decode_ctrl: combinational instruction -> ctrl/branch_sel decoder; register file inline.

Verification
REQ-040 Reset then wb x5=0xDEADBEEF, ADD x1,x5,x0 -> a_o=0xDEADBEEF, ctrl_o.fs=0000, ex_valid=1 one cycle later.
REQ-041 Same-cycle wb x7=0x1234 and decode ADD x2,x7,x7 -> a_o=b_o=0x1234.
REQ-042 LW x3,0(x1) then ADD x4,x3,x3 back-to-back -> one bubble, if_ready=0 one cycle, stall_cnt_o=1.
REQ-043 ex_ready=0 for 3 cycles -> all outputs stable, if_ready=0; flush=1 -> ex_valid=0 next edge.
REQ-044 instruction_i=0x00000000 -> ctrl_o=0, branch_sel_o=000; write to x0 then read -> 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - RV32I major opcode constants
//   - function-select (fs) and branch-select codes
//   - ctrl_t: packed control word driven to execute,
//     {rd, rs2, rs1, fs, we, mr, md, mb, mem_type}, CTRL_W bits wide
//   - ctrl_zero(): the all-zero control word used for bubbles
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Plain add: address generation and LUI/AUIPC pass-through
  localparam logic [3:0] FS_ADD = 4'b0000;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_COND = 3'b100;

  localparam int CTRL_W = 26;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [3:0] fs;
    logic       we;
    logic       mr;
    logic       md;
    logic       mb;
    logic [2:0] mem_type;
  } ctrl_t;

  function automatic ctrl_t ctrl_zero();
    return ctrl_t'(26'd0);
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I instruction decoder.
//   instruction_i : raw 32-bit instruction
//   ctrl_o        : control word (see decode_pkg::ctrl_t)
//   branch_sel_o  : 001 JAL, 010 JALR, 100 conditional branch, else 000
// Any opcode outside the supported RV32I set (including compressed
// encodings, instr[1:0] != 2'b11) yields an all-zero bubble.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [31:0] instruction_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  branch_sel_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       f7b_s;
  logic       unused_bits_s;

  assign opcode_s      = instruction_i[6:0];
  assign funct3_s      = instruction_i[14:12];
  assign f7b_s         = instruction_i[30];
  assign unused_bits_s = ^{instruction_i[31], instruction_i[29:25]};

  // Opcode to control-word mapping; register fields only survive on known opcodes
  always_comb begin
    ctrl_o       = ctrl_zero();
    branch_sel_o = BR_NONE;
    ctrl_o.rd    = instruction_i[11:7];
    ctrl_o.rs1   = instruction_i[19:15];
    ctrl_o.rs2   = instruction_i[24:20];
    case (opcode_s)
      OPC_LOAD: begin
        ctrl_o.we       = 1'b1;
        ctrl_o.mr       = 1'b1;
        ctrl_o.mb       = 1'b1;
        ctrl_o.fs       = FS_ADD;
        ctrl_o.mem_type = funct3_s;
      end
      OPC_STORE: begin
        ctrl_o.md       = 1'b1;
        ctrl_o.mb       = 1'b1;
        ctrl_o.fs       = FS_ADD;
        ctrl_o.mem_type = funct3_s;
      end
      OPC_OP: begin
        ctrl_o.we = 1'b1;
        ctrl_o.fs = {f7b_s, funct3_s};
      end
      OPC_OP_IMM: begin
        // Only the shift-right group uses bit 30 (SRAI); elsewhere it is immediate data
        ctrl_o.we = 1'b1;
        ctrl_o.mb = 1'b1;
        ctrl_o.fs = {(funct3_s == 3'b101) & f7b_s, funct3_s};
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_o.we = 1'b1;
        ctrl_o.mb = 1'b1;
        ctrl_o.fs = FS_ADD;
      end
      OPC_JAL: begin
        ctrl_o.we    = 1'b1;
        branch_sel_o = BR_JAL;
      end
      OPC_JALR: begin
        ctrl_o.we    = 1'b1;
        ctrl_o.mb    = 1'b1;
        branch_sel_o = BR_JALR;
      end
      OPC_BRANCH: begin
        ctrl_o.mem_type = funct3_s;
        branch_sel_o    = BR_COND;
      end
      default: begin
        ctrl_o       = ctrl_zero();
        branch_sel_o = BR_NONE;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-back bypass, instruction
// decode and the ID/EX pipeline register with valid/ready handshake.
//   clk, reset (sync, active-low)
//   if_valid/if_ready, instruction_i, imm_i, pc_plus_i, pred_taken_i : fetch side
//   flush                                  : kill held and incoming entry
//   wb_we/wb_rd/wb_data                    : register write-back port
//   ex_ready/ex_valid, a_o, b_o, store_data_o, pc_plus_o, ctrl_o,
//   branch_sel_o, pred_taken_o             : registered execute side
//   stall_cnt_o                            : load-use bubble count
// Build option: define DECODE_HAZARD_EN to add the load-use interlock and
// stall_cnt_o; without it hazard resolution belongs to execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       instruction_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_plus_i,
  input  logic              pred_taken_i,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   a_o,
  output logic [XLEN-1:0]   b_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [XLEN-1:0]   pc_plus_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [2:0]        branch_sel_o,
  output logic              pred_taken_o
`ifdef DECODE_HAZARD_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  ctrl_t             ctrl_dec_s;
  logic [2:0]        bsel_dec_s;
  logic [REG_AW-1:0] rs1_idx_s;
  logic [REG_AW-1:0] rs2_idx_s;
  logic [XLEN-1:0]   rs1_data_s;
  logic [XLEN-1:0]   rs2_data_s;
  logic              hazard_s;
  logic              accept_s;

  logic [XLEN-1:0]   regs_r [NREGS];
  logic              ex_valid_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   store_data_r;
  logic [XLEN-1:0]   pc_plus_r;
  ctrl_t             ctrl_r;
  logic [2:0]        bsel_r;
  logic              pred_taken_r;

  decode_ctrl u_ctrl (
    .instruction_i (instruction_i),
    .ctrl_o        (ctrl_dec_s),
    .branch_sel_o  (bsel_dec_s)
  );

  assign rs1_idx_s = instruction_i[15 +: REG_AW];
  assign rs2_idx_s = instruction_i[20 +: REG_AW];

  // Register file write port; x0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {XLEN{1'b0}};
    end else if (wb_we && (wb_rd != {REG_AW{1'b0}})) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // rs1 read with same-cycle write-back forwarding
  always_comb begin
    if (rs1_idx_s == {REG_AW{1'b0}}) rs1_data_s = {XLEN{1'b0}};
    else if (wb_we && (wb_rd == rs1_idx_s)) rs1_data_s = wb_data;
    else rs1_data_s = regs_r[rs1_idx_s];
  end

  // rs2 read with same-cycle write-back forwarding
  always_comb begin
    if (rs2_idx_s == {REG_AW{1'b0}}) rs2_data_s = {XLEN{1'b0}};
    else if (wb_we && (wb_rd == rs2_idx_s)) rs2_data_s = wb_data;
    else rs2_data_s = regs_r[rs2_idx_s];
  end

`ifdef DECODE_HAZARD_EN
  // Held load whose destination feeds the incoming instruction cannot be bypassed here
  assign hazard_s = ex_valid_r & ctrl_r.mr & (ctrl_r.rd != 5'd0) & if_valid &
                    ((ctrl_r.rd == instruction_i[19:15]) | (ctrl_r.rd == instruction_i[24:20]));
`else
  assign hazard_s = 1'b0;
`endif

  // Flush always frees the slot so upstream can drain the wrong path
  assign if_ready = flush | ((~ex_valid_r | ex_ready) & ~hazard_s);
  assign accept_s = if_valid & if_ready & ~flush;

  // ID/EX register: load on accept, drain when consumed, hold under back-pressure
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid_r   <= 1'b0;
      a_r          <= {XLEN{1'b0}};
      b_r          <= {XLEN{1'b0}};
      store_data_r <= {XLEN{1'b0}};
      pc_plus_r    <= {XLEN{1'b0}};
      ctrl_r       <= ctrl_zero();
      bsel_r       <= BR_NONE;
      pred_taken_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r   <= 1'b1;
      a_r          <= rs1_data_s;
      b_r          <= ctrl_dec_s.mb ? imm_i : rs2_data_s;
      store_data_r <= rs2_data_s;
      pc_plus_r    <= pc_plus_i;
      ctrl_r       <= ctrl_dec_s;
      bsel_r       <= bsel_dec_s;
      pred_taken_r <= pred_taken_i;
    end else if (!ex_valid_r || ex_ready) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

`ifdef DECODE_HAZARD_EN
  logic [31:0] stall_cnt_r;

  // Count bubbles actually inserted by the interlock, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (!flush && hazard_s && ex_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

  assign ex_valid     = ex_valid_r;
  assign a_o          = a_r;
  assign b_o          = b_r;
  assign store_data_o = store_data_r;
  assign pc_plus_o    = pc_plus_r;
  assign ctrl_o       = ctrl_r;
  assign branch_sel_o = bsel_r;
  assign pred_taken_o = pred_taken_r;

endmodule
